// File: rtl/sprom_arb_pkg.sv
// ----------------------------------------------------------------------------
// sprom_arb_pkg
// Shared definitions for the sprom_arbiter block: requester-count limits,
// the index-width helper and the stage-1 pipeline tag.
// No ports (package).
// ----------------------------------------------------------------------------
package sprom_arb_pkg;

    // Largest supported requester count and the id width that covers it.
    localparam int MAX_NREQ = 8;
    localparam int MAX_ID_W = 3;

    // Width of a requester index; never below 1 bit so the vectors stay legal.
    function automatic int ID_W(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Tag carried alongside an in-flight ROM read.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/sprom_arbiter_if.sv
// ----------------------------------------------------------------------------
// sprom_arbiter_if
// Requester-side bus of the ROM arbiter.
//   req    : per-requester read request (level, held until granted)
//   addr   : per-requester address, requester i at [i*AW +: AW]
//   gnt    : one-hot accept, combinational
//   rvalid : one-hot, one-cycle data-valid pulse
//   rdata  : shared read data, qualified by rvalid
// Modports: master (requesters), slave (arbiter).
// ----------------------------------------------------------------------------
interface sprom_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 10,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/sprom_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker. The search starts one past i_last and
// wraps modulo NREQ; only requests with their i_mask bit set take part.
//   i_req  : request vector
//   i_last : index of the previous winner
//   i_mask : eligibility mask
//   o_gnt  : one-hot grant (all zero when nothing eligible)
//   o_idx  : winner index (0 when nothing eligible)
//   o_any  : a winner was found
// ----------------------------------------------------------------------------
module rr_pick
    import sprom_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    input  logic [NREQ-1:0] i_mask,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [NREQ-1:0] w_req_m;
    logic            w_found;
    logic            w_hit;
    int              w_pos;

    assign w_req_m = i_req & i_mask;

    // Walk the candidates in rotated order; the first eligible one wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_hit   = 1'b0;
        w_pos   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos        = (int'(i_last) + k) % NREQ;
            w_hit        = w_req_m[w_pos] & ~w_found;
            o_gnt[w_pos] = w_hit;
            o_idx        = w_hit ? IW'(w_pos) : o_idx;
            w_found      = w_found | w_hit;
        end
        o_any = w_found;
    end

endmodule

// File: rtl/sprom_arbiter.sv
// ----------------------------------------------------------------------------
// sprom_arbiter
// Shares one synchronous single-port ROM (registered address, one-cycle read
// latency) among NREQ requesters. One grant per cycle, data returns two cycles
// after the grant, in grant order.
//   clk      : clock, rising edge
//   rst      : asynchronous, active-high reset
//   bus      : requester bus (sprom_arbiter_if.slave)
//   rom_ce   : ROM chip enable, high in every grant cycle
//   rom_oe   : registered copy of rom_ce
//   rom_addr : granted address, 0 when idle
//   rom_do   : ROM read data
// Build option: define SPROM_ARB_FIXED_PRIO_EN to give requester 0 absolute
// priority, with requesters 1..NREQ-1 sharing round-robin among themselves.
// ----------------------------------------------------------------------------
module sprom_arbiter
    import sprom_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 10,
    parameter int DW   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    sprom_arbiter_if.slave        bus,
    output logic                  rom_ce,
    output logic                  rom_oe,
    output logic [AW-1:0]         rom_addr,
    input  logic [DW-1:0]         rom_do
);

    localparam int IW = ID_W(NREQ);

    logic [IW-1:0]   r_last;
    tag_t            r_s1;
    logic [NREQ-1:0] r_rvalid;
    logic [DW-1:0]   r_rdata;
    logic            r_rom_oe;

    logic [NREQ-1:0] w_mask;
    logic [NREQ-1:0] w_pick_gnt;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic [NREQ-1:0] w_gnt_raw;
    logic [IW-1:0]   w_idx;
    logic            w_upd_last;
    logic [NREQ-1:0] w_gnt;
    logic            w_any;
    logic [AW-1:0]   w_rom_addr;

`ifdef SPROM_ARB_FIXED_PRIO_EN
    // Requester 0 is outside the rotation; the picker only sees 1..NREQ-1.
    assign w_mask = {{(NREQ-1){1'b1}}, 1'b0};
`else
    assign w_mask = {NREQ{1'b1}};
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req  (bus.req),
        .i_last (r_last),
        .i_mask (w_mask),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

`ifdef SPROM_ARB_FIXED_PRIO_EN
    // Requester 0 pre-empts the rotation and leaves the pointer untouched.
    always_comb begin
        if (bus.req[0]) begin
            w_gnt_raw  = {{(NREQ-1){1'b0}}, 1'b1};
            w_idx      = '0;
            w_upd_last = 1'b0;
        end else begin
            w_gnt_raw  = w_pick_gnt;
            w_idx      = w_pick_idx;
            w_upd_last = w_pick_any;
        end
    end
`else
    // Pure round-robin: the picker result is the grant.
    always_comb begin
        w_gnt_raw  = w_pick_gnt;
        w_idx      = w_pick_idx;
        w_upd_last = w_pick_any;
    end
`endif

    // Nothing is granted while reset is held, so no access can start then.
    assign w_gnt = w_gnt_raw & {NREQ{~rst}};
    assign w_any = |w_gnt;

    // AND-OR mux of the winner's address; all zeros when idle.
    always_comb begin
        w_rom_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rom_addr = w_rom_addr | (bus.addr[i*AW +: AW] & {AW{w_gnt[i]}});
        end
    end

    assign bus.gnt    = w_gnt;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
    assign rom_ce     = w_any;
    assign rom_addr   = w_rom_addr;
    assign rom_oe     = r_rom_oe;

    // Round-robin pointer: index of the last rotating winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= IW'(NREQ - 1);
        end else if (w_upd_last) begin
            r_last <= w_idx;
        end else begin
            r_last <= r_last;
        end
    end

    // Stage 1: remember who was granted while the ROM performs the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= '0;
            r_rom_oe <= 1'b0;
        end else begin
            r_s1.valid <= w_any;
            r_s1.id    <= MAX_ID_W'(w_idx);
            r_rom_oe   <= w_any;
        end
    end

    // Stage 2: capture ROM data and pulse the owner's rvalid; rdata holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else if (r_s1.valid) begin
            r_rvalid <= {{(NREQ-1){1'b0}}, 1'b1} << r_s1.id;
            r_rdata  <= rom_do;
        end else begin
            r_rvalid <= '0;
            r_rdata  <= r_rdata;
        end
    end

endmodule

// File: tb/tb_sprom_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sprom_arbiter
// Directed vectors with hand-computed grants; each grant pushes the expected
// read response into a scoreboard queue that a separate monitor drains when
// rvalid appears. Build with SPROM_ARB_FIXED_PRIO_EN for the priority variant.
// ----------------------------------------------------------------------------
module tb_sprom_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
`ifdef SPROM_ARB_FIXED_PRIO_EN
    localparam int NREQ = 3;
`else
    localparam int NREQ = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rom_ce;
    logic          rom_oe;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_do = '0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic prev_ce = 1'b0;

    typedef struct {
        logic          rst;
        logic [2:0]    req;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [2:0]    gnt;
    } vec_t;

    typedef struct {
        logic [NREQ-1:0] onehot;
        logic [DW-1:0]   data;
        int              at;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    sprom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    sprom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rom_ce   (rom_ce),
        .rom_oe   (rom_oe),
        .rom_addr (rom_addr),
        .rom_do   (rom_do)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: 0xDEADBEEF at 5, elsewhere a tag plus the address.
    function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
        if (a == 10'd5) return 32'hDEADBEEF;
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    // ROM model: registered address, one-cycle latency.
    always @(posedge clk) if (rom_ce) rom_do <= rom_val(rom_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [3*AW-1:0] af;
        logic [NREQ-1:0] eg;
        logic [AW-1:0]   ea;
        @(negedge clk);
        if (v.rst) sbq.delete();
        rst      = v.rst;
        af       = {v.a2, v.a1, v.a0};
        bus.req  = v.req[NREQ-1:0];
        bus.addr = af[NREQ*AW-1:0];
        eg       = v.gnt[NREQ-1:0];
        ea       = '0;
        for (int i = 0; i < NREQ; i++) if (eg[i]) ea = af[i*AW +: AW];
        #1;
        chk("gnt", bus.gnt, eg);
        chk("rom_ce", rom_ce, |eg);
        chk("rom_addr", rom_addr, ea);
        chk("rom_oe", rom_oe, v.rst ? 1'b0 : prev_ce);
        if (v.rst) begin
            chk("rst_rvalid", bus.rvalid, 0);
            chk("rst_rdata", bus.rdata, 0);
        end
        prev_ce = |eg;
        if (|eg) sbq.push_back('{eg, rom_val(ea), cyc + 2});
    endtask

    function automatic vec_t V(input logic r, input logic [2:0] q, input logic [AW-1:0] a0,
                               input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [2:0] g);
        vec_t v;
        v.rst = r; v.req = q; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.gnt = g;
        return v;
    endfunction

    // Monitor: every rvalid pulse must match the oldest outstanding grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rvalid !== '0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rvalid", bus.rvalid, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rvalid", bus.rvalid, e.onehot);
                    chk("rdata", bus.rdata, e.data);
                    chk("latency", cyc, e.at);
                end
            end
        end
    end

    initial begin
        bus.req  = '0;
        bus.addr = '0;
`ifdef SPROM_ARB_FIXED_PRIO_EN
        vecs.push_back(V(1'b1, 3'b111, 10'h1, 10'h2, 10'h3, 3'b000));
        vecs.push_back(V(1'b1, 3'b111, 10'h1, 10'h2, 10'h3, 3'b000));
        repeat (4) vecs.push_back(V(1'b0, 3'b111, 10'h1, 10'h2, 10'h3, 3'b001));
        vecs.push_back(V(1'b0, 3'b110, 10'h1, 10'h2, 10'h3, 3'b010));
        vecs.push_back(V(1'b0, 3'b110, 10'h1, 10'h2, 10'h3, 3'b100));
        vecs.push_back(V(1'b0, 3'b110, 10'h1, 10'h2, 10'h3, 3'b010));
        vecs.push_back(V(1'b0, 3'b110, 10'h1, 10'h2, 10'h3, 3'b100));
        vecs.push_back(V(1'b0, 3'b111, 10'h1, 10'h2, 10'h3, 3'b001));
        vecs.push_back(V(1'b0, 3'b110, 10'h1, 10'h2, 10'h3, 3'b010));
        repeat (3) vecs.push_back(V(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 3'b000));
`else
        // Reset held with requests pending: nothing granted.
        vecs.push_back(V(1'b1, 3'b011, 10'h10, 10'h20, 10'h0, 3'b000));
        vecs.push_back(V(1'b1, 3'b011, 10'h10, 10'h20, 10'h0, 3'b000));
        // Same-cycle first request after reset: 0 then 1.
        vecs.push_back(V(1'b0, 3'b011, 10'h10, 10'h20, 10'h0, 3'b001));
        vecs.push_back(V(1'b0, 3'b011, 10'h10, 10'h20, 10'h0, 3'b010));
        // Idle: pointer stays at 1.
        repeat (5) vecs.push_back(V(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 3'b000));
        // Single request to address 5.
        vecs.push_back(V(1'b0, 3'b001, 10'h5, 10'h0, 10'h0, 3'b001));
        repeat (2) vecs.push_back(V(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 3'b000));
        // Both continuous; last winner was 0, so 1 goes first.
        vecs.push_back(V(1'b0, 3'b011, 10'h10, 10'h20, 10'h0, 3'b010));
        vecs.push_back(V(1'b0, 3'b011, 10'h10, 10'h20, 10'h0, 3'b001));
        vecs.push_back(V(1'b0, 3'b011, 10'h10, 10'h20, 10'h0, 3'b010));
        vecs.push_back(V(1'b0, 3'b011, 10'h10, 10'h20, 10'h0, 3'b001));
        // Back-to-back same requester, then top address from requester 1.
        vecs.push_back(V(1'b0, 3'b001, 10'h3, 10'h0, 10'h0, 3'b001));
        vecs.push_back(V(1'b0, 3'b001, 10'h4, 10'h0, 10'h0, 3'b001));
        vecs.push_back(V(1'b0, 3'b010, 10'h0, 10'h3FF, 10'h0, 3'b010));
        repeat (2) vecs.push_back(V(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 3'b000));
        // Grant, then reset the next cycle: the access is dropped.
        vecs.push_back(V(1'b0, 3'b001, 10'h7, 10'h0, 10'h0, 3'b001));
        vecs.push_back(V(1'b1, 3'b000, 10'h0, 10'h0, 10'h0, 3'b000));
        vecs.push_back(V(1'b1, 3'b000, 10'h0, 10'h0, 10'h0, 3'b000));
        vecs.push_back(V(1'b0, 3'b011, 10'h11, 10'h22, 10'h0, 3'b001));
        vecs.push_back(V(1'b0, 3'b011, 10'h11, 10'h22, 10'h0, 3'b010));
        repeat (3) vecs.push_back(V(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 3'b000));
`endif
        foreach (vecs[i]) apply(vecs[i]);
        repeat (3) @(negedge clk);
        chk("pending_responses", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprom_arbiter.md
# sprom_arbiter

Shares one synchronous single-port ROM (`sprom`, registered read address, one-cycle read latency) among `NREQ` independent requesters. Each requester uses a simple req/gnt/rvalid handshake, so several blocks (CPU fetch, video fetch, loader readback) can use one ROM instance. The arbiter sits between the requesters and the ROM port. It is fully pipelined: one access per cycle, with a fixed 2-cycle latency from grant to data.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (2..8).
- `AW`, 10, ROM address width; must match the ROM's `aw`.
- `DW`, 32, ROM data width; must match the ROM's `dw`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  per-requester read request, level; held until granted.
- `addr`  in  NREQ*AW  per-requester address; requester i occupies bits [i*AW +: AW]; stable while `req[i]` is high.
- `gnt`  out  NREQ  one-hot, combinational; `gnt[i]` high means requester i is accepted this cycle.
- `rvalid`  out  NREQ  one-hot, registered; a 1-cycle pulse marking `rdata` valid for requester i.
- `rdata`  out  DW  registered read data, shared by all requesters; qualified by `rvalid`.
- `rom_ce`  out  1  to ROM `ce`; high in every grant cycle.
- `rom_oe`  out  1  to ROM `oe`; registered copy of `rom_ce`.
- `rom_addr`  out  AW  to ROM `addr`; the granted requester's address, 0 when idle.
- `rom_do`  in  DW  from ROM `do`.

## Operation
- Cycle N arbitration:
  - If any `req` bit is set, exactly one `gnt` bit is set in the same cycle.
  - `rom_ce=1` and `rom_addr` is the winner's address.
  - `gnt[i]` never goes high unless `req[i]` is high.
- Round-robin pointer `last` (log2 NREQ bits) holds the index of the last winner.
  - The search starts at `last+1` and wraps modulo NREQ.
  - `last` updates on every grant and is unchanged on idle cycles.
- Pipeline tags:
  - Stage 1 (`s1_v`, `s1_id`) captures the grant at the end of cycle N.
  - In cycle N+1, `rom_do` is valid for `s1_id`.
  - At the end of cycle N+1, `rdata` <= `rom_do` and `rvalid[s1_id]` <= 1.
- Back-to-back grants are allowed, to the same or different requesters. `rvalid` pulses come back in grant order.
- A requester that keeps `req` high after its grant is treated as issuing a new request.
- There is no backpressure on read data; requesters must accept `rvalid` in the cycle it is asserted.
- Fairness: with all requesters continuously active, each one is granted exactly once in every NREQ consecutive cycles.
- Reset values:
  - `last` = NREQ-1, so requester 0 has first priority after reset.
  - `s1_v`=0, `rvalid`=0, `rdata`=0, `rom_oe`=0.
  - `gnt`, `rom_ce`, `rom_addr` are 0 while `rst` is high.
- Reset mid-operation: in-flight accesses are dropped and no `rvalid` is produced for them.

## Timing
- `gnt` and `rom_ce` are combinational from `req` and `last`; there is no combinational path from `rom_do`.
- Latency: a grant in cycle N gives `rvalid` and `rdata` in cycle N+2.
- Throughput: one access per cycle.
- `rdata` holds its last value when `rvalid`=0.

## Configuration
- `SPROM_ARB_FIXED_PRIO_EN` defined:
  - Requester 0 wins whenever `req[0]` is high.
  - Requesters 1..NREQ-1 are round-robin among themselves. `last` tracks only their grants; a requester-0 grant leaves it unchanged.
  - Requester 0 can starve the others; this is intended for the CPU fetch path.
- Not defined: pure round-robin across all requesters, as described under Operation.

## Structure
- Package `sprom_arb_pkg`:
  - `ID_W = $clog2(NREQ)` helper function.
  - `MAX_NREQ = 8` constant.
  - The tag struct {valid, id}.
- One sub-module, `rr_pick`:
  - Combinational rotate-priority picker with inputs `req`, `last` and an optional mask.
  - Outputs a one-hot grant and the winner index.
  - Used for both the full round-robin set and the masked 1..N-1 set.
- The top level holds `last`, the stage-1 tag, the `rdata`/`rvalid` registers and the address mux.

## Test plan
- Single request: `req=01`, `addr0=0x005`, ROM[5]=0xDEADBEEF → `gnt=01` in cycle 0; `rvalid=01`, `rdata=0xDEADBEEF` in cycle 2.
- Both requesters continuous, addresses 0x010 and 0x020, round-robin build → grants alternate 01,10,01,10; `rvalid` follows 2 cycles later with the matching ROM data.
- Same-cycle first request after reset, `req=11` → requester 0 granted first, requester 1 next cycle.
- `SPROM_ARB_FIXED_PRIO_EN` build, NREQ=3, `req=111` held for 4 cycles → `gnt=001` every cycle; after `req[0]` drops, grants to 1 and 2 alternate.
- Assert `rst` the cycle after a grant → no `rvalid` during or after reset; `rdata=0`; the first post-reset grant goes to requester 0.
- Idle: `req=0` for 5 cycles → `rom_ce=0`, `rom_addr=0`, `rvalid=0`, `last` unchanged.
